// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 boot-EEPROM read emulator (READ 0x03, RDSR 0x05) with host load port; SPI_RESP_WRITE_EN adds WREN/WRITE.
// Latency: 3 clk from pin change to action (2-FF sync + edge register); first READ bit valid 1 clk after the fall ending address bit 0.
// Backpressure: none; the SPI master paces transfers (>=4 clk per SPI phase), load-port writes are accepted every cycle.
module spi_eeprom_responder #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic              busy
);
    // Input shift only needs enough history for the opcode and the kept address bits.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;

`ifdef SPI_RESP_WRITE_EN
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_READ, S_STATUS, S_IGNORE, S_WRITE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_READ, S_STATUS, S_IGNORE} state_t;
`endif

    state_t            state, state_n;
    logic [1:0]        sclk_sync, mosi_sync, ss_sync;
    logic              sclk_d, ss_d, rel, armed;
    logic              sclk_s, mosi_s, ss_s;
    logic              rise, fall, ss_fall, ss_rise;
    logic [SH_W-1:0]   shift_in;
    logic [3:0]        bit_cnt;
    logic [2:0]        out_cnt;
    logic [7:0]        shift_out, cmd_byte, status_byte;
    logic [ADDR_W-1:0] addr, addr_word, addr_inc;
    logic              miso_q, wel;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    // armed is only set once ss has been seen high after reset, so a transfer
    // interrupted by reset is not resumed until the master re-selects us.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_sync   <= 2'b11;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            rel       <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], mosi};
            ss_sync   <= {ss_sync[0], ss};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            rel       <= 1'b1;
            if (rel && ss_sync[0])
                armed <= 1'b1;
        end
    end

    assign sclk_s      = sclk_sync[1];
    assign mosi_s      = mosi_sync[1];
    assign ss_s        = ss_sync[1];
    assign ss_fall     = armed & ss_d & ~ss_s;
    assign ss_rise     = ~ss_d & ss_s;
    assign rise        = sclk_s & ~sclk_d & ~ss_s;
    assign fall        = ~sclk_s & sclk_d & ~ss_s;
    assign busy        = ~ss_s;
    assign cmd_byte    = {shift_in[6:0], mosi_s};
    assign addr_word   = {shift_in[ADDR_W-2:0], mosi_s};
    assign addr_inc    = addr + ADDR_W'(1);
    assign status_byte = {6'b0, wel, 1'b0};
    assign miso        = miso_q & ((state == S_READ) || (state == S_STATUS));

`ifdef SPI_RESP_WRITE_EN
    logic is_write, wren_pend, spi_we;
    assign spi_we = rise && (state == S_WRITE) && (bit_cnt == 4'd7) && wel;
`else
    assign wel = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (ss_rise) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (ss_fall) state_n = S_CMD;
                S_CMD: begin
                    if (rise && bit_cnt == 4'd7) begin
                        case (cmd_byte)
                            8'h03:   state_n = S_ADDR;
                            8'h05:   state_n = S_STATUS;
`ifdef SPI_RESP_WRITE_EN
                            8'h02:   state_n = S_ADDR;
`endif
                            default: state_n = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (rise && bit_cnt == 4'd15) begin
`ifdef SPI_RESP_WRITE_EN
                        state_n = is_write ? S_WRITE : S_READ;
`else
                        state_n = S_READ;
`endif
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_in  <= '0;
            bit_cnt   <= '0;
            out_cnt   <= '0;
            shift_out <= '0;
            miso_q    <= 1'b0;
            addr      <= '0;
`ifdef SPI_RESP_WRITE_EN
            wel       <= 1'b0;
            is_write  <= 1'b0;
            wren_pend <= 1'b0;
`endif
        end else if (ss_rise || state == S_IDLE) begin
            shift_in <= '0;
            bit_cnt  <= '0;
            out_cnt  <= '0;
            miso_q   <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
            if (ss_rise) begin
                if (is_write)
                    wel <= 1'b0;
                else if (wren_pend)
                    wel <= 1'b1;
                is_write  <= 1'b0;
                wren_pend <= 1'b0;
            end
`endif
        end else begin
            if (rise) begin
                shift_in <= {shift_in[SH_W-2:0], mosi_s};
                bit_cnt  <= bit_cnt + 4'd1;
                if (state == S_CMD && bit_cnt == 4'd7) begin
                    bit_cnt   <= '0;
                    out_cnt   <= '0;
                    shift_out <= status_byte;
`ifdef SPI_RESP_WRITE_EN
                    is_write  <= (cmd_byte == 8'h02);
                    wren_pend <= (cmd_byte == 8'h06);
`endif
                end
                if (state == S_ADDR && bit_cnt == 4'd15) begin
                    bit_cnt   <= '0;
                    out_cnt   <= '0;
                    addr      <= addr_word;
                    shift_out <= mem[addr_word];
                end
`ifdef SPI_RESP_WRITE_EN
                if (state == S_WRITE && bit_cnt == 4'd7) begin
                    bit_cnt <= '0;
                    addr    <= addr_inc;
                end
`endif
            end
            // The 8th fall shifts out bit 0 and preloads the next byte in the same cycle.
            if (fall && (state == S_READ || state == S_STATUS)) begin
                miso_q  <= shift_out[7];
                out_cnt <= out_cnt + 3'd1;
                if (out_cnt == 3'd7) begin
                    if (state == S_READ) begin
                        addr      <= addr_inc;
                        shift_out <= mem[addr_inc];
                    end else begin
                        shift_out <= status_byte;
                    end
                end else begin
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    // Load port wins over an SPI write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
`ifdef SPI_RESP_WRITE_EN
        else if (spi_we)
            mem[addr] <= cmd_byte;
`endif
    end
endmodule
